param_dm_cache_ctrl: RTL and testbench
======================================

// Module: param_dm_cache_ctrl
// PURPOSE
//  Parametrised direct-mapped cache with its own miss/refill controller. It sits between the CPU
//  load/store port and the RAM interface. Read misses are refilled a whole line at a time from RAM.
//  Writes are write-through, no-write-allocate. Word 0 of a line occupies the line MSBs.
// PARAMETERS
//  ADDR_W   15  word address width; TAG_W = ADDR_W-INDEX_W-OFF_W
//  WORD_W   32  data word width
//  OFF_W     2  log2(words per line); LINE_W = WORD_W<<OFF_W
//  INDEX_W  10  log2(number of lines)
// PORTS
//  globalclock  in   1        single clock, all logic on posedge
//  reset        in   1        synchronous, active-low
//  cpu_req      in   1        request, sampled only in IDLE
//  cpu_wr       in   1        1 = write, 0 = read
//  cpu_addr     in   ADDR_W   word address {tag,index,offset}
//  cpu_wdata    in   WORD_W   write data
//  cpu_rdata    out  WORD_W   read data, valid while cpu_ack=1
//  cpu_ack      out  1        one-cycle completion pulse
//  hit          out  1        lookup result, valid while cpu_ack=1
//  mem_req      out  1        RAM request, held until mem_ack
//  mem_we       out  1        1 = word write, 0 = line read
//  mem_addr     out  ADDR_W   word addr (write) / line addr with offset=0 (read)
//  mem_wdata    out  WORD_W   write-through data
//  mem_rdata    in   LINE_W   refill line, sampled on mem_ack
//  mem_ack      in   1        RAM completion, one cycle
//  hit_cnt      out  32       hits (see CONFIGURATION)
//  miss_cnt     out  32       misses (see CONFIGURATION)
// BEHAVIOUR
//  - Storage: data[2^INDEX_W] x LINE_W, tag[2^INDEX_W] x TAG_W, valid bit vector held in flops.
//  - Reset (reset=0 at a clock edge): state=IDLE; all valid bits=0.
//    cpu_ack, hit, mem_req, mem_we, counters=0. cpu_rdata, mem_addr, mem_wdata=0.
//    Reset aborts any operation in flight. A mem_ack arriving later is ignored.
//  - IDLE: if cpu_req=1, latch addr, wr and wdata, then go to LOOKUP. Otherwise stay in IDLE.
//  - LOOKUP: hit = valid[idx] && tag[idx]==addr tag.
//    - Read hit: load the selected word into cpu_rdata, go to RESP.
//    - Read miss: mem_req=1, mem_we=0, mem_addr={tag,idx,0}, go to REFILL.
//    - Write, hit or miss: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata, go to WRITE.
//      On a hit, the word is also updated in the line in this cycle.
//  - REFILL: hold mem_* until mem_ack. On mem_ack: write the line, set tag and valid[idx]=1,
//    take cpu_rdata from the requested word, mem_req=0, go to RESP.
//  - WRITE: hold mem_* until mem_ack. On mem_ack: mem_req=0, mem_we=0, go to RESP.
//    A write miss allocates nothing.
//  - RESP: cpu_ack=1 for exactly one cycle, hit holds the LOOKUP result, then go to IDLE.
//  - Latency from cpu_req sample to cpu_ack:
//    - read hit: 2 cycles;
//    - miss or write: 2 cycles plus the mem_ack wait.
//    Back-to-back requests are accepted every 3rd cycle at best.
//  - cpu_req outside IDLE is ignored and not queued. mem_ack outside REFILL/WRITE is ignored.
//  - Word select: offset k maps to line bits [LINE_W-1-k*WORD_W -: WORD_W].
//  - One line per index; a conflicting tag evicts silently. No dirty state (write-through).
// CONFIGURATION
//  CACHE_STATS_EN defined:
//    - hit_cnt increments on each RESP with hit=1; miss_cnt on each RESP with hit=0.
//    - Both counters saturate at 32'hFFFFFFFF and clear on reset.
//  CACHE_STATS_EN undefined: no counter logic; hit_cnt and miss_cnt are constant 0.
// TESTING (defaults: TAG_W=3, INDEX_W=10, OFF_W=2)
//  1. After reset, read 0x1004 -> mem_req=1, mem_we=0, mem_addr=0x1004.
//     Then mem_ack with line 0xAAAA0000_BBBB1111_CCCC2222_DDDD3333
//     -> cpu_ack with cpu_rdata=0xAAAA0000, hit=0.
//  2. Read 0x1006 -> cpu_ack 2 cycles after the req sample, cpu_rdata=0xCCCC2222, hit=1, mem_req stays 0.
//  3. Read 0x2004 (same index, new tag) -> miss and refill.
//     A following read of 0x1004 -> hit=0 again (evicted).
//  4. Write 0x2005 <= 0x12345678 -> mem_req=1, mem_we=1, mem_addr=0x2005, then ack with hit=1.
//     Read 0x2005 -> hit=1, 0x12345678.
//     Write 0x3008 (miss), then read 0x3008 -> hit=0 (no allocate).
//  5. Drive reset=0 while in REFILL -> next cycle mem_req=0, cpu_ack=0.
//     A late mem_ack is ignored. Re-reading 0x1006 -> miss.
//  6. CACHE_STATS_EN defined: after scenarios 1-3 -> hit_cnt=1, miss_cnt=3.
//     Undefined: both read 0 throughout.

Source files
------------

// File: rtl/param_dm_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache with its own refill controller.
// Defining CACHE_STATS_EN adds saturating hit/miss counters; otherwise both read 0.
module param_dm_cache_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int WORD_W  = 32,
  parameter int OFF_W   = 2,
  parameter int INDEX_W = 10
) (
  input  logic                       globalclock,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_wr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [WORD_W-1:0]          cpu_wdata,
  output logic [WORD_W-1:0]          cpu_rdata,
  output logic                       cpu_ack,
  output logic                       hit,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [WORD_W-1:0]          mem_wdata,
  input  logic [(WORD_W<<OFF_W)-1:0] mem_rdata,
  input  logic                       mem_ack,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
);

  localparam int          TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int          LINE_W = WORD_W << OFF_W;
  localparam int          LINES  = 1 << INDEX_W;
  localparam int unsigned WORDS  = 1 << OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_t;
  state_t state_q, state_d;

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              hit_q, hit_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [WORD_W-1:0] mwdata_q, mwdata_d;

  logic [OFF_W-1:0]   off_f;
  logic [INDEX_W-1:0] idx_f;
  logic [TAG_W-1:0]   tag_f;
  logic [LINE_W-1:0]  cur_line, upd_line, data_wline;
  logic [WORD_W-1:0]  hit_word, fill_word;
  logic               lookup_hit, data_we, fill_en;

  assign off_f      = addr_q[OFF_W-1:0];
  assign idx_f      = addr_q[OFF_W +: INDEX_W];
  assign tag_f      = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_line   = data_q[idx_f];
  assign lookup_hit = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

  // Word 0 sits in the line MSBs.
  always_comb begin
    hit_word  = '0;
    fill_word = '0;
    upd_line  = cur_line;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (off_f == OFF_W'(k)) begin
        hit_word  = cur_line[LINE_W-1-k*WORD_W -: WORD_W];
        fill_word = mem_rdata[LINE_W-1-k*WORD_W -: WORD_W];
        upd_line[LINE_W-1-k*WORD_W -: WORD_W] = wdata_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    hit_d      = hit_q;
    mreq_d     = mreq_q;
    mwe_d      = mwe_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    data_we    = 1'b0;
    data_wline = upd_line;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wr_d    = cpu_wr;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        if (wr_q) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = addr_q;
          mwdata_d = wdata_q;
          data_we  = lookup_hit;
          state_d  = S_WRITE;
        end else if (lookup_hit) begin
          rdata_d = hit_word;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {tag_f, idx_f, {OFF_W{1'b0}}};
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          data_we    = 1'b1;
          data_wline = mem_rdata;
          fill_en    = 1'b1;
          rdata_d    = fill_word;
          mreq_d     = 1'b0;
          ack_d      = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge globalclock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      if (fill_en) valid_q[idx_f] <= 1'b1;
    end
  end

  // Line and tag storage carries no reset; valid_q alone qualifies it.
  always_ff @(posedge globalclock) begin
    if (reset && data_we) data_q[idx_f] <= data_wline;
    if (reset && fill_en) tag_q[idx_f] <= tag_f;
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign hit       = hit_q;
  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge globalclock) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_RESP) begin
      if (hit_q && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit_q && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_param_dm_cache_ctrl.sv
// Self-checking bench for param_dm_cache_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural cache/RAM model.
module tb_param_dm_cache_ctrl;

  logic         globalclock;
  logic         reset;
  logic         cpu_req, cpu_wr;
  logic [14:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ack, hit;
  logic         mem_req, mem_we;
  logic [14:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt, miss_cnt;

  int passed = 0;
  int total  = 0;

  param_dm_cache_ctrl #(.ADDR_W(15), .WORD_W(32), .OFF_W(2), .INDEX_W(10)) dut (
    .globalclock(globalclock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: cache contents, backing RAM and hit/miss totals
  logic         m_valid [1024];
  logic [2:0]   m_tag   [1024];
  logic [127:0] m_line  [1024];
  logic [31:0]  ram     [int];
  int unsigned  m_hits, m_miss;

  function automatic logic [31:0] ram_rd(input logic [14:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] build_line(input logic [14:0] la);
    return {ram_rd(la), ram_rd(la + 15'd1), ram_rd(la + 15'd2), ram_rd(la + 15'd3)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_access(input logic wr, input logic [14:0] a, input logic [31:0] wd,
                              input logic [127:0] line, output logic eh, output logic [31:0] erd);
    int unsigned idx, sh;
    logic [127:0] tmp;
    idx = int'(a[11:2]);
    sh  = 32 * (3 - int'(a[1:0]));
    eh  = m_valid[idx] && (m_tag[idx] == a[14:12]);
    erd = '0;
    if (!wr) begin
      if (!eh) begin
        m_line[idx]  = line;
        m_tag[idx]   = a[14:12];
        m_valid[idx] = 1'b1;
      end
      tmp = m_line[idx] >> sh;
      erd = tmp[31:0];
    end else begin
      ram[int'(a)] = wd;
      if (eh) m_line[idx] = (m_line[idx] & ~(128'hFFFF_FFFF << sh)) | (128'(wd) << sh);
    end
    if (eh) m_hits++; else m_miss++;
  endtask

  // Runs one CPU transaction; answers the RAM after d extra cycles. Returns observations only.
  task automatic cpu_access(input logic wr, input logic [14:0] a, input logic [31:0] wd,
                            input logic [127:0] line, input int d,
                            output logic [31:0] rd, output logic h, output int lat, output int memcyc,
                            output logic mwe, output logic [14:0] maddr, output logic [31:0] mwd,
                            output logic ack2);
    rd = '0; h = 1'b0; lat = -1; memcyc = 0; mwe = 1'b0; maddr = '0; mwd = '0; ack2 = 1'b0;
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge globalclock);
      cpu_req   = 1'b0;
      cpu_wdata = $urandom;
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (cpu_ack) begin
        lat = n; rd = cpu_rdata; h = hit;
      end else if (mem_req) begin
        if (memcyc == 0) begin mwe = mem_we; maddr = mem_addr; mwd = mem_wdata; end
        if (memcyc == d) begin mem_ack = 1'b1; mem_rdata = line; end
        memcyc++;
      end
    end
    mem_ack = 1'b0;
    @(negedge globalclock);
    ack2 = cpu_ack;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge globalclock);
    total++; if ({cpu_ack, hit, mem_req, mem_we} !== 4'b0) $display("FAIL reset_ctrl got=%b exp=0000", {cpu_ack, hit, mem_req, mem_we}); else passed++;
    total++; if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); else passed++;
    total++; if ({mem_addr, mem_wdata} !== 47'h0) $display("FAIL reset_mem got=%h/%h exp=0", mem_addr, mem_wdata); else passed++;
    total++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL reset_cnt got=%0d/%0d exp=0", hit_cnt, miss_cnt); else passed++;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_stats(input string tag);
    logic [31:0] eh, em;
`ifdef CACHE_STATS_EN
    eh = m_hits; em = m_miss;
`else
    eh = 0; em = 0;
`endif
    total++; if (hit_cnt !== eh) $display("FAIL %s_hit_cnt got=%0d exp=%0d", tag, hit_cnt, eh); else passed++;
    total++; if (miss_cnt !== em) $display("FAIL %s_miss_cnt got=%0d exp=%0d", tag, miss_cnt, em); else passed++;
  endtask

  task automatic test_refill_and_hit();
    logic [127:0] ln;
    logic [31:0] rd, mwd, erd;
    logic h, mwe, ack2, eh;
    logic [14:0] ma;
    int lat, mc;
    ln = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    model_access(1'b0, 15'h1004, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h1004, '0, ln, 1, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({mwe, ma} !== {1'b0, 15'h1004}) $display("FAIL s1_memreq got=we%b/%h exp=we0/1004", mwe, ma); else passed++;
    total++; if (rd !== 32'hAAAA0000) $display("FAIL s1_rdata got=%h exp=AAAA0000", rd); else passed++;
    total++; if (h !== 1'b0) $display("FAIL s1_hit got=%b exp=0", h); else passed++;
    total++; if (lat !== 4 || mc !== 2) $display("FAIL s1_timing got=lat%0d/mem%0d exp=lat4/mem2", lat, mc); else passed++;
    total++; if (ack2 !== 1'b0) $display("FAIL s1_ack_pulse got=%b exp=0", ack2); else passed++;
    model_access(1'b0, 15'h1006, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h1006, '0, ln, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({h, rd} !== {1'b1, 32'hCCCC2222}) $display("FAIL s2_hit got=%b/%h exp=1/CCCC2222", h, rd); else passed++;
    total++; if (lat !== 2 || mc !== 0) $display("FAIL s2_timing got=lat%0d/mem%0d exp=lat2/mem0", lat, mc); else passed++;
  endtask

  task automatic test_evict();
    logic [127:0] ln;
    logic [31:0] rd, mwd, erd;
    logic h, mwe, ack2, eh;
    logic [14:0] ma;
    int lat, mc;
    ln = build_line(15'h2004);
    model_access(1'b0, 15'h2004, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h2004, '0, ln, 2, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({h, rd, ma} !== {1'b0, erd, 15'h2004}) $display("FAIL s3_conflict got=%b/%h/%h exp=0/%h/2004", h, rd, ma, erd); else passed++;
    ln = 128'h11111111_22222222_33333333_44444444;
    model_access(1'b0, 15'h1004, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h1004, '0, ln, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({h, rd} !== {1'b0, 32'h11111111}) $display("FAIL s3_evicted got=%b/%h exp=0/11111111", h, rd); else passed++;
  endtask

  task automatic test_write_through();
    logic [127:0] ln;
    logic [31:0] rd, mwd, erd;
    logic h, mwe, ack2, eh;
    logic [14:0] ma;
    int lat, mc;
    ln = build_line(15'h2004);
    model_access(1'b0, 15'h2004, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h2004, '0, ln, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    model_access(1'b1, 15'h2005, 32'h12345678, '0, eh, erd);
    cpu_access(1'b1, 15'h2005, 32'h12345678, '0, 1, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({mwe, ma, mwd} !== {1'b1, 15'h2005, 32'h12345678}) $display("FAIL s4_wr_mem got=%b/%h/%h exp=1/2005/12345678", mwe, ma, mwd); else passed++;
    total++; if ({h, lat} !== {1'b1, 32'd4}) $display("FAIL s4_wr_hit got=%b/lat%0d exp=1/lat4", h, lat); else passed++;
    cpu_access(1'b0, 15'h2005, '0, '0, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    model_access(1'b0, 15'h2005, '0, '0, eh, erd);
    total++; if ({h, rd, mc} !== {1'b1, 32'h12345678, 32'd0}) $display("FAIL s4_rd_updated got=%b/%h/mem%0d exp=1/12345678/mem0", h, rd, mc); else passed++;
    model_access(1'b1, 15'h3008, 32'hCAFEF00D, '0, eh, erd);
    cpu_access(1'b1, 15'h3008, 32'hCAFEF00D, '0, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if (h !== 1'b0) $display("FAIL s4_wr_miss got=%b exp=0", h); else passed++;
    ln = build_line(15'h3008);
    model_access(1'b0, 15'h3008, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h3008, '0, ln, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({h, rd} !== {1'b0, 32'hCAFEF00D}) $display("FAIL s4_no_allocate got=%b/%h exp=0/CAFEF00D", h, rd); else passed++;
  endtask

  task automatic test_reset_in_refill();
    logic [127:0] ln;
    logic [31:0] rd, mwd, erd;
    logic h, mwe, ack2, eh;
    logic [14:0] ma;
    int lat, mc;
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h5004;
    @(negedge globalclock);
    cpu_req = 1'b0;
    @(negedge globalclock);
    total++; if (mem_req !== 1'b1) $display("FAIL s5_in_refill got=%b exp=1", mem_req); else passed++;
    reset = 1'b0;
    @(negedge globalclock);
    total++; if ({mem_req, cpu_ack, cpu_rdata} !== 34'h0) $display("FAIL s5_aborted got=%b/%b/%h exp=0/0/0", mem_req, cpu_ack, cpu_rdata); else passed++;
    reset = 1'b1;
    model_reset();
    @(negedge globalclock);
    mem_ack = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
    @(negedge globalclock);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge globalclock);
      total++; if ({cpu_ack, mem_req} !== 2'b00) $display("FAIL s5_late_ack cyc=%0d got=%b/%b exp=0/0", i, cpu_ack, mem_req); else passed++;
    end
    ln = 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D;
    model_access(1'b0, 15'h1006, '0, ln, eh, erd);
    cpu_access(1'b0, 15'h1006, '0, ln, 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    total++; if ({h, rd, ma} !== {1'b0, 32'h0C0C0C0C, 15'h1004}) $display("FAIL s5_reread got=%b/%h/%h exp=0/0C0C0C0C/1004", h, rd, ma); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [14:0] sampled [13];
    logic [31:0] rd, mwd, erd;
    logic h, mwe, ack2, eh;
    logic [14:0] ma;
    int lat, mc;
    cpu_access(1'b0, 15'h0100, '0, build_line(15'h0100), 0, rd, h, lat, mc, mwe, ma, mwd, ack2);
    model_access(1'b0, 15'h0100, '0, build_line(15'h0100), eh, erd);
    for (int c = 0; c <= 12; c++) begin
      @(negedge globalclock);
      if (c >= 2 && (c % 3) == 2) begin
        model_access(1'b0, sampled[c-2], '0, '0, eh, erd);
        total++; if ({cpu_ack, hit, cpu_rdata} !== {1'b1, 1'b1, erd}) $display("FAIL b2b_resp cyc=%0d got=%b/%b/%h exp=1/1/%h", c, cpu_ack, hit, cpu_rdata, erd); else passed++;
      end else begin
        total++; if (cpu_ack !== 1'b0) $display("FAIL b2b_idle cyc=%0d got=%b exp=0", c, cpu_ack); else passed++;
      end
      sampled[c] = {13'h0040, 2'($urandom)};
      cpu_req = (c < 12); cpu_wr = 1'b0; cpu_addr = sampled[c];
    end
    cpu_req = 1'b0;
    @(negedge globalclock);
  endtask

  task automatic test_random();
    logic [127:0] ln;
    logic [31:0] rd, wd, mwd, erd;
    logic h, mwe, ack2, eh, wr;
    logic [14:0] ma, a;
    int lat, mc, d, sel;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 3);
      a   = {3'($urandom), (sel == 3) ? 10'h3FF : 10'(sel), 2'($urandom)};
      wr  = ($urandom_range(0, 9) < 3);
      wd  = $urandom;
      d   = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge globalclock);
        mem_ack = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge globalclock);
        mem_ack = 1'b0;
      end
      ln = build_line({a[14:2], 2'b00});
      model_access(wr, a, wd, ln, eh, erd);
      cpu_access(wr, a, wd, ln, d, rd, h, lat, mc, mwe, ma, mwd, ack2);
      total++; if (h !== eh) $display("FAIL rnd_hit i=%0d addr=%h got=%b exp=%b", i, a, h, eh); else passed++;
      if (!wr) begin
        total++; if (rd !== erd) $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, rd, erd); else passed++;
      end
      if (wr || !eh) begin
        total++; if (lat !== 3 + d || mc !== d + 1) $display("FAIL rnd_mem_timing i=%0d got=lat%0d/mem%0d exp=lat%0d/mem%0d", i, lat, mc, 3 + d, d + 1); else passed++;
        total++; if ({mwe, ma} !== {wr, wr ? a : {a[14:2], 2'b00}}) $display("FAIL rnd_mem_addr i=%0d got=%b/%h exp=%b/%h", i, mwe, ma, wr, wr ? a : {a[14:2], 2'b00}); else passed++;
        if (wr) begin
          total++; if (mwd !== wd) $display("FAIL rnd_mem_wdata i=%0d got=%h exp=%h", i, mwd, wd); else passed++;
        end
      end else begin
        total++; if (lat !== 2 || mc !== 0) $display("FAIL rnd_hit_timing i=%0d got=lat%0d/mem%0d exp=lat2/mem0", i, lat, mc); else passed++;
      end
      total++; if (ack2 !== 1'b0) $display("FAIL rnd_ack_pulse i=%0d got=%b exp=0", i, ack2); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_refill_and_hit();
    test_evict();
    test_stats("s6");
    test_write_through();
    test_reset_in_refill();
    test_stats("s5_after_reset");
    test_back_to_back();
    test_random();
    test_stats("final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
